// File: rtl/hazard_scheduler_pkg.sv
// rtl/hazard_scheduler_pkg.sv - shared constants, slot type and helpers for the hazard scheduler
package hazard_scheduler_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Scoreboard slot field widths
    localparam int REG_W      = 5;
    localparam int SLOT_W     = 1 + REG_W + 1;

    // Default width of the stall and flush counters
    localparam int HZ_CNT_W_DEF = 16;

    // Slot index inside the per-slot match vectors
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } sb_slot_t;

    // A slot only claims a source when the reader actually uses it; $0 is never a producer
    function automatic logic slot_match(input sb_slot_t slot,
                                        input logic [REG_W-1:0] src,
                                        input logic use_src);
        return use_src && slot.valid && (slot.dest != '0) && (slot.dest == src);
    endfunction

    // Youngest producer wins: EX (about to be MEM) beats MEM (about to be WB)
    function automatic logic [1:0] fwd_select(input logic [1:0] ex_mem_match);
        if (ex_mem_match[0]) begin
            return FWD_MEM;
        end
        if (ex_mem_match[1]) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - three-slot destination scoreboard (EX, MEM, WB) with bubble insertion
module hz_scoreboard
    import hazard_scheduler_pkg::*;
(
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             bubble,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic             D_use_rs,
    input  logic             D_use_rt,
    input  logic [REG_W-1:0] D_write_register,
    input  logic             D_RegWrite,
    input  logic             D_MemRead,
    output logic [2:0]       rs_match,
    output logic [2:0]       rt_match,
    output logic             ex_is_load
);

    sb_slot_t ex_q;
    sb_slot_t mem_q;
    sb_slot_t wb_q;
    sb_slot_t ex_next;

    // The instruction leaving Decode, or an empty slot when a bubble is injected
    always_comb begin
        ex_next = '0;
        if (!bubble) begin
            ex_next.valid   = D_RegWrite;
            ex_next.dest    = D_write_register;
            ex_next.is_load = D_MemRead;
        end
    end

    // Shift the scoreboard on the pipeline update edge
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_next;
        end
    end

    // Per-slot comparison against both Decode source fields
    always_comb begin
        rs_match           = '0;
        rt_match           = '0;
        rs_match[SLOT_EX]  = slot_match(ex_q,  D_rs, D_use_rs);
        rs_match[SLOT_MEM] = slot_match(mem_q, D_rs, D_use_rs);
        rs_match[SLOT_WB]  = slot_match(wb_q,  D_rs, D_use_rs);
        rt_match[SLOT_EX]  = slot_match(ex_q,  D_rt, D_use_rt);
        rt_match[SLOT_MEM] = slot_match(mem_q, D_rt, D_use_rt);
        rt_match[SLOT_WB]  = slot_match(wb_q,  D_rt, D_use_rt);
    end

    assign ex_is_load = ex_q.is_load;

    // The load flag is irrelevant once the producer has reached WB
    logic unused_wb_load;
    assign unused_wb_load = wb_q.is_load;

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - MIPS hazard controller (stall, bubble, flush, forwarding); forwarding enabled by HZ_FORWARD_EN
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = HZ_CNT_W_DEF
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic             D_use_rs,
    input  logic             D_use_rt,
    input  logic [REG_W-1:0] D_write_register,
    input  logic             D_RegWrite,
    input  logic             D_MemRead,
    input  logic             EX_branch_taken,
    output logic             HZ_stall,
    output logic             HZ_bubble_EX,
    output logic             HZ_flush_D,
    output logic [1:0]       HZ_fwd_a,
    output logic [1:0]       HZ_fwd_b,
    output logic [CNT_W-1:0] HZ_stall_count,
    output logic [CNT_W-1:0] HZ_flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] rs_match;
    logic [2:0] rt_match;
    logic       ex_is_load;
    logic       hazard;

    hz_scoreboard u_scoreboard (
        .SYS_clk          (SYS_clk),
        .SYS_reset        (SYS_reset),
        .bubble           (HZ_bubble_EX),
        .D_rs             (D_rs),
        .D_rt             (D_rt),
        .D_use_rs         (D_use_rs),
        .D_use_rt         (D_use_rt),
        .D_write_register (D_write_register),
        .D_RegWrite       (D_RegWrite),
        .D_MemRead        (D_MemRead),
        .rs_match         (rs_match),
        .rt_match         (rt_match),
        .ex_is_load       (ex_is_load)
    );

`ifdef HZ_FORWARD_EN
    // Only a load still in EX cannot be forwarded in time
    assign hazard = ex_is_load & (rs_match[SLOT_EX] | rt_match[SLOT_EX]);

    logic unused_wb_match;
    assign unused_wb_match = rs_match[SLOT_WB] ^ rt_match[SLOT_WB];
`else
    // Without forwarding the consumer waits until its producer has left WB
    assign hazard = (|rs_match) | (|rt_match);

    logic unused_ex_load;
    assign unused_ex_load = ex_is_load;
`endif

    // A taken branch wins: the stalled Decode instruction is wrong-path
    assign HZ_flush_D   = EX_branch_taken;
    assign HZ_bubble_EX = hazard | EX_branch_taken;
    assign HZ_stall     = hazard & ~EX_branch_taken;

`ifdef HZ_FORWARD_EN
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // Operand sources for the instruction entering EX; a bubble needs none
    always_comb begin
        fwd_a_next = FWD_REG;
        fwd_b_next = FWD_REG;
        if (!HZ_bubble_EX) begin
            fwd_a_next = fwd_select(rs_match[1:0]);
            fwd_b_next = fwd_select(rt_match[1:0]);
        end
    end

    // Hold the selects for the whole cycle in which the instruction executes
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            HZ_fwd_a <= FWD_REG;
            HZ_fwd_b <= FWD_REG;
        end else begin
            HZ_fwd_a <= fwd_a_next;
            HZ_fwd_b <= fwd_b_next;
        end
    end
`else
    assign HZ_fwd_a = FWD_REG;
    assign HZ_fwd_b = FWD_REG;
`endif

    // Saturating count of cycles spent stalled
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            HZ_stall_count <= '0;
        end else if (HZ_stall && (HZ_stall_count != CNT_MAX)) begin
            HZ_stall_count <= HZ_stall_count + 1'b1;
        end
    end

    // Saturating count of taken-branch flushes
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            HZ_flush_count <= '0;
        end else if (HZ_flush_D && (HZ_flush_count != CNT_MAX)) begin
            HZ_flush_count <= HZ_flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - self-checking bench for hazard_scheduler (directed plus randomized)
module tb_hazard_scheduler;

    logic       SYS_clk = 1'b0;
    logic       SYS_reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic [4:0] d_wr;
    logic       d_regwrite;
    logic       d_memread;
    logic       br;

    logic        hz_stall, hz_bubble, hz_flush;
    logic [1:0]  hz_fwd_a, hz_fwd_b;
    logic [15:0] hz_scnt, hz_fcnt;
    logic        sm_stall, sm_bubble, sm_flush;
    logic [1:0]  sm_fwd_a, sm_fwd_b;
    logic [3:0]  sm_scnt, sm_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 SYS_clk = ~SYS_clk;

    hazard_scheduler dut (
        .SYS_clk (SYS_clk), .SYS_reset (SYS_reset),
        .D_rs (d_rs), .D_rt (d_rt), .D_use_rs (d_use_rs), .D_use_rt (d_use_rt),
        .D_write_register (d_wr), .D_RegWrite (d_regwrite), .D_MemRead (d_memread),
        .EX_branch_taken (br),
        .HZ_stall (hz_stall), .HZ_bubble_EX (hz_bubble), .HZ_flush_D (hz_flush),
        .HZ_fwd_a (hz_fwd_a), .HZ_fwd_b (hz_fwd_b),
        .HZ_stall_count (hz_scnt), .HZ_flush_count (hz_fcnt)
    );

    hazard_scheduler #(.CNT_W(4)) dut_small (
        .SYS_clk (SYS_clk), .SYS_reset (SYS_reset),
        .D_rs (d_rs), .D_rt (d_rt), .D_use_rs (d_use_rs), .D_use_rt (d_use_rt),
        .D_write_register (d_wr), .D_RegWrite (d_regwrite), .D_MemRead (d_memread),
        .EX_branch_taken (br),
        .HZ_stall (sm_stall), .HZ_bubble_EX (sm_bubble), .HZ_flush_D (sm_flush),
        .HZ_fwd_a (sm_fwd_a), .HZ_fwd_b (sm_fwd_b),
        .HZ_stall_count (sm_scnt), .HZ_flush_count (sm_fcnt)
    );

    // Reference model: instructions in flight after Decode, youngest first
    typedef struct {
        bit       writes;
        bit [4:0] dest;
        bit       is_load;
    } prod_t;

    prod_t    inflight[$];
    int       m_age_a, m_age_b;
    bit       m_stall, m_bubble, m_flush;
    bit [1:0] m_fwd_a, m_fwd_b;
    int       m_scnt, m_fcnt, m_sscnt, m_sfcnt;

    logic       cap_stall, cap_bubble, cap_flush;
    logic [1:0] cap_fwd_a, cap_fwd_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Distance (0 = just issued) to the youngest in-flight writer of src, -1 if none
    function automatic int producer_age(input bit [4:0] src, input bit use_src);
        if (!use_src || src == 5'd0) return -1;
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].writes && inflight[i].dest == src) return i;
        return -1;
    endfunction

    function automatic bit [1:0] age_to_sel(input int age);
        if (age == 0) return 2'b01;
        if (age == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        prod_t empty;
        empty.writes = 0; empty.dest = 0; empty.is_load = 0;
        inflight.delete();
        for (int i = 0; i < 3; i++) inflight.push_back(empty);
        m_fwd_a = 0; m_fwd_b = 0;
        m_scnt = 0; m_fcnt = 0; m_sscnt = 0; m_sfcnt = 0;
    endtask

    task automatic model_eval();
        bit hz;
        m_age_a = producer_age(d_rs, d_use_rs);
        m_age_b = producer_age(d_rt, d_use_rt);
`ifdef HZ_FORWARD_EN
        hz = (m_age_a == 0 || m_age_b == 0) && inflight[0].is_load;
`else
        hz = (m_age_a >= 0) || (m_age_b >= 0);
`endif
        m_flush  = br;
        m_bubble = hz || br;
        m_stall  = hz && !br;
    endtask

    task automatic model_edge();
        prod_t p;
        if (SYS_reset) begin
            model_reset();
            return;
        end
`ifdef HZ_FORWARD_EN
        m_fwd_a = m_bubble ? 2'b00 : age_to_sel(m_age_a);
        m_fwd_b = m_bubble ? 2'b00 : age_to_sel(m_age_b);
`else
        m_fwd_a = 2'b00;
        m_fwd_b = 2'b00;
`endif
        if (m_stall) begin
            if (m_scnt < 65535) m_scnt++;
            if (m_sscnt < 15) m_sscnt++;
        end
        if (m_flush) begin
            if (m_fcnt < 65535) m_fcnt++;
            if (m_sfcnt < 15) m_sfcnt++;
        end
        p.writes  = m_bubble ? 1'b0 : d_regwrite;
        p.dest    = m_bubble ? 5'd0 : d_wr;
        p.is_load = m_bubble ? 1'b0 : d_memread;
        inflight.push_front(p);
        void'(inflight.pop_back());
    endtask

    // One pipeline cycle: compare mid-cycle, then let the negedge update happen
    task automatic step();
        @(posedge SYS_clk);
        #1;
        model_eval();
        cap_stall = hz_stall; cap_bubble = hz_bubble; cap_flush = hz_flush;
        cap_fwd_a = hz_fwd_a; cap_fwd_b = hz_fwd_b;
        check("stall", hz_stall, m_stall);
        check("bubble", hz_bubble, m_bubble);
        check("flush", hz_flush, m_flush);
        check("fwd_a", hz_fwd_a, m_fwd_a);
        check("fwd_b", hz_fwd_b, m_fwd_b);
        check("stall_cnt", hz_scnt, m_scnt);
        check("flush_cnt", hz_fcnt, m_fcnt);
        check("sm_stall", sm_stall, m_stall);
        check("sm_fwd_a", {sm_fwd_a, sm_fwd_b}, {m_fwd_a, m_fwd_b});
        check("sm_stall_cnt", sm_scnt, m_sscnt);
        check("sm_flush_cnt", sm_fcnt, m_sfcnt);
        check("sm_bub_flush", {sm_bubble, sm_flush}, {m_bubble, m_flush});
        @(negedge SYS_clk);
        model_edge();
        #1;
    endtask

    task automatic set_d(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                         input bit [4:0] wr, input bit rw, input bit mr);
        d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
        d_wr = wr; d_regwrite = rw; d_memread = mr;
    endtask

    task automatic set_idle();
        set_d(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        SYS_reset = 1'b1;
        set_idle();
        br = 1'b0;
        step();
        SYS_reset = 1'b0;
    endtask

    initial begin
        SYS_reset = 1'b1;
        br = 1'b0;
        set_idle();
        model_reset();
        @(negedge SYS_clk);
        #1;
        SYS_reset = 1'b0;

        // Reset state
        step();
        check("rst_outs", {cap_stall, cap_bubble, cap_flush}, 3'b000);
        check("rst_fwd", {cap_fwd_a, cap_fwd_b}, 4'b0000);
        check("rst_cnts", {hz_scnt, hz_fcnt}, 32'h0);

        // ALU back-to-back dependence
        do_reset();
        set_d(1, 1, 1, 1, 2, 1, 0); step();
`ifdef HZ_FORWARD_EN
        set_d(2, 2, 1, 1, 3, 1, 0); step();
        check("alu_no_stall", cap_stall, 1'b0);
        set_idle(); step();
        check("alu_fwd", {cap_fwd_a, cap_fwd_b}, 4'b0101);
`else
        set_d(2, 0, 1, 1, 3, 1, 0); step();
        check("nofwd_stall1", cap_stall, 1'b1);
        step(); check("nofwd_stall2", cap_stall, 1'b1);
        step(); check("nofwd_stall3", cap_stall, 1'b1);
        step(); check("nofwd_release", cap_stall, 1'b0);
        set_idle(); step();
        check("nofwd_cnt", hz_scnt, 16'd3);
`endif

        // Load-use dependence
        do_reset();
        set_d(1, 0, 1, 0, 2, 1, 1); step();
        set_d(2, 1, 1, 1, 4, 1, 0); step();
        check("lu_stall", {cap_stall, cap_bubble}, 2'b11);
`ifdef HZ_FORWARD_EN
        step();
        check("lu_release", cap_stall, 1'b0);
        set_idle(); step();
        check("lu_fwd", {cap_fwd_a, cap_fwd_b}, 4'b1000);
        check("lu_cnt", hz_scnt, 16'd1);
`else
        step(); step(); step();
        check("lu_release", cap_stall, 1'b0);
        set_idle(); step();
        check("lu_cnt", hz_scnt, 16'd3);
`endif

        // Register $0 never creates a dependence
        do_reset();
        set_d(0, 0, 0, 0, 0, 1, 1); step();
        set_d(0, 0, 1, 1, 5, 1, 0); step();
        check("r0_no_stall", cap_stall, 1'b0);
        set_idle(); step();
        check("r0_fwd", {cap_fwd_a, cap_fwd_b}, 4'b0000);

        // Taken branch together with a load-use condition
        do_reset();
        set_d(0, 0, 0, 0, 5, 1, 1); step();
        set_d(5, 5, 1, 1, 6, 1, 0); br = 1'b1; step();
        check("br_outs", {cap_flush, cap_stall, cap_bubble}, 3'b101);
        br = 1'b0; set_idle(); step();
        check("br_cnts", {hz_fcnt, hz_scnt}, {16'd1, 16'd0});

        // Saturation of the narrow counters
        do_reset();
        for (int i = 0; i < 20; i++) begin
            br = 1'b1; step();
        end
        br = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_d(0, 0, 0, 0, 7, 1, 1); step();
            set_d(7, 0, 1, 0, 8, 1, 0); step();
        end
        check("sat_small", {sm_scnt, sm_fcnt}, 8'hFF);
        check("sat_big", {hz_scnt, hz_fcnt}, {16'd20, 16'd20});

        // Reset asserted in the middle of a stall
        set_d(0, 0, 0, 0, 7, 1, 1); step();
        set_d(7, 0, 1, 0, 8, 1, 0); SYS_reset = 1'b1; step();
        check("rs_stall_seen", cap_stall, 1'b1);
        SYS_reset = 1'b0;
        check("rs_cnts", {hz_scnt, hz_fcnt, sm_scnt, sm_fcnt}, 40'h0);
        check("rs_fwd", {hz_fwd_a, hz_fwd_b}, 4'b0000);
        step();
        check("rs_no_stall", {cap_stall, cap_bubble, cap_flush}, 3'b000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (!m_stall) begin
                d_rs       = 5'($urandom_range(0, 3));
                d_rt       = 5'($urandom_range(0, 3));
                d_use_rs   = ($urandom_range(0, 3) != 0);
                d_use_rt   = ($urandom_range(0, 1) != 0);
                d_wr       = 5'($urandom_range(0, 3));
                d_regwrite = ($urandom_range(0, 3) != 0);
                d_memread  = d_regwrite && ($urandom_range(0, 2) == 0);
            end
            br        = ($urandom_range(0, 7) == 0);
            SYS_reset = ($urandom_range(0, 63) == 0);
            step();
        end
        SYS_reset = 1'b0;
        br = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
